cmlb_refill: RTL

- Miss handler directly downstream of the code MLB (cmlb) lookup.
- Detects fetch-translation misses, stalls fetch, and issues a page-walk request with a valid/ready handshake.
- On walk response, writes the entry back into cmlb through its write_wen/write_data port, then releases fetch for replay.
- Turns walk faults and timeouts into a single-cycle fault report to the fetch unit.

---
 rtl/cmlb_refill_pkg.sv | 34 +++
 rtl/cmlb_refill_timer.sv | 44 ++++
 rtl/cmlb_refill.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/cmlb_refill_pkg.sv
// ============================================================================
//  Module      : cmlb_refill_pkg
//  Description : Shared constants and state encoding for the code-MLB refill
//                (miss handler) block and its timeout sub-module.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// The translation payload width normally comes from the core's struct.sv.
// When this slice is built on its own the fallback below keeps it complete.
`ifndef cmlbData_width
`define cmlbData_width 64
`endif

package cmlb_refill_pkg;

   localparam int unsigned c_IP_WIDTH    = 65;
   localparam int unsigned c_DATA_WIDTH  = `cmlbData_width;
   localparam int unsigned c_TIMEOUT     = 1023;
   localparam int unsigned c_TIMER_WIDTH = 11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_WAIT   = 3'd2,
      ST_FILL   = 3'd3,
      ST_REPLAY = 3'd4,
      ST_FAULT  = 3'd5,
      ST_DRAIN  = 3'd6
   } state_t;

endpackage

`default_nettype wire

// File: rtl/cmlb_refill_timer.sv
// ============================================================================
//  Module      : cmlb_refill_timer
//  Description : Cycle counter used to bound the wait for a page-walk response.
//                Cleared on request, counts while enabled, and flags expiry
//                while enabled once the count has reached LIMIT.
//  Ports       : clk, rst      - clock / synchronous active-high reset
//                i_clear       - restart the count from zero
//                i_en          - count this cycle
//                o_expire      - count has reached LIMIT while enabled
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmlb_refill_timer #(
   parameter int unsigned WIDTH = 11,
   parameter int unsigned LIMIT = 1023
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_en,
   output logic o_expire
);

   logic [WIDTH-1:0] r_cnt;
   logic             w_at_limit;

   assign w_at_limit = (r_cnt == WIDTH'(LIMIT));
   assign o_expire   = i_en & w_at_limit;

   // The count parks at LIMIT so it can never wrap back to a live value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_en && !w_at_limit) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/cmlb_refill.sv
// ============================================================================
//  Module      : cmlb_refill
//  Description : Code-MLB miss handler. Detects fetch-translation misses,
//                stalls fetch, issues one page-walk request (valid/ready),
//                writes the returned entry into the cmlb, then releases fetch
//                for replay. Walk faults become a one-cycle fault pulse.
//  Options     : CMLB_REFILL_TIMEOUT_EN - bound WAIT/DRAIN by TIMEOUT cycles
//                (WAIT expiry reports a fault, DRAIN expiry returns to idle).
//  Ports       : clk, rst                 - clock / sync active-high reset
//                i_lookup_*               - cmlb lookup of this cycle
//                i_flush                  - fetch redirect, cancels a miss
//                o_stall                  - fetch stall request
//                o_req_* / i_req_ready    - page-walk request handshake
//                i_rsp_*                  - page-walk response
//                o_mlb_*                  - cmlb write port / address mux
//                o_fault_valid/addr       - one-cycle fault report
//                o_miss_count             - saturating miss counter
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmlb_refill
   import cmlb_refill_pkg::*;
#(
   parameter int unsigned IP_WIDTH   = c_IP_WIDTH,
   parameter int unsigned DATA_WIDTH = c_DATA_WIDTH,
   parameter int unsigned TIMEOUT    = c_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_lookup_en,
   input  logic [IP_WIDTH-1:0]   i_lookup_addr,
   input  logic                  i_lookup_tr,
   input  logic                  i_lookup_hit,
   input  logic                  i_flush,
   output logic                  o_stall,
   output logic                  o_req_valid,
   input  logic                  i_req_ready,
   output logic [IP_WIDTH-1:0]   o_req_addr,
   output logic                  o_req_tr,
   input  logic                  i_rsp_valid,
   input  logic [DATA_WIDTH-1:0] i_rsp_data,
   input  logic                  i_rsp_fault,
   output logic                  o_mlb_wen,
   output logic [DATA_WIDTH-1:0] o_mlb_wdata,
   output logic [IP_WIDTH-1:0]   o_mlb_addr,
   output logic                  o_mlb_tr,
   output logic                  o_fault_valid,
   output logic [IP_WIDTH-1:0]   o_fault_addr,
   output logic [15:0]           o_miss_count
);

   state_t                r_state;
   state_t                w_next;
   logic [IP_WIDTH-1:0]   r_addr;
   logic                  r_tr;
   logic [DATA_WIDTH-1:0] r_data;
   logic [15:0]           r_miss_count;
   logic                  w_miss;
   logic                  w_expire;

   // A flush in the miss cycle wins: the lookup is being redirected anyway.
   assign w_miss = i_lookup_en & ~i_lookup_hit & ~i_flush;

`ifdef CMLB_REFILL_TIMEOUT_EN
   logic w_tmr_en;
   logic w_tmr_clr;

   assign w_tmr_en  = (r_state == ST_WAIT) | (r_state == ST_DRAIN);
   // Restart on every entry into a waiting state, including WAIT -> DRAIN.
   assign w_tmr_clr = ((w_next == ST_WAIT) | (w_next == ST_DRAIN)) & (w_next != r_state);

   cmlb_refill_timer #(
      .WIDTH (c_TIMER_WIDTH),
      .LIMIT (TIMEOUT)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (w_tmr_clr),
      .i_en     (w_tmr_en),
      .o_expire (w_expire)
   );
`else
   assign w_expire = 1'b0;
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_miss) w_next = ST_REQ;
         end
         ST_REQ: begin
            // A walk already accepted must still be drained on flush.
            if (i_req_ready && i_flush)  w_next = ST_DRAIN;
            else if (i_flush)            w_next = ST_IDLE;
            else if (i_req_ready)        w_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (i_flush && i_rsp_valid)  w_next = ST_IDLE;
            else if (i_flush)            w_next = ST_DRAIN;
            else if (i_rsp_valid)        w_next = i_rsp_fault ? ST_FAULT : ST_FILL;
            else if (w_expire)           w_next = ST_FAULT;
         end
         ST_FILL:   w_next = ST_REPLAY;
         ST_REPLAY: w_next = ST_IDLE;
         ST_FAULT:  w_next = ST_IDLE;
         ST_DRAIN: begin
            if (i_rsp_valid || w_expire) w_next = ST_IDLE;
         end
         default:   w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_addr       <= '0;
         r_tr         <= 1'b0;
         r_data       <= '0;
         r_miss_count <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_IDLE && w_miss) begin
            r_addr <= i_lookup_addr;
            r_tr   <= i_lookup_tr;
            if (r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
         end
         if (r_state == ST_WAIT && i_rsp_valid && !i_rsp_fault && !i_flush) begin
            r_data <= i_rsp_data;
         end
      end
   end

   assign o_stall       = (r_state != ST_IDLE) | w_miss;
   assign o_req_valid   = (r_state == ST_REQ);
   assign o_req_addr    = r_addr;
   assign o_req_tr      = r_tr;
   assign o_mlb_wen     = (r_state == ST_FILL);
   assign o_mlb_wdata   = r_data;
   // The cmlb address port is borrowed only for the single fill cycle.
   assign o_mlb_addr    = (r_state == ST_FILL) ? r_addr : i_lookup_addr;
   assign o_mlb_tr      = (r_state == ST_FILL) ? r_tr   : i_lookup_tr;
   assign o_fault_valid = (r_state == ST_FAULT);
   assign o_fault_addr  = r_addr;
   assign o_miss_count  = r_miss_count;

endmodule

`default_nettype wire
